// File: rtl/if_stage_pkg.sv
// Shared widths, reset level, FSM encodings and the fetch payload for if_stage.
package if_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic RST_ENABLE = 1'b1;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  localparam logic [1:0] IF_S_IDLE = 2'd0;
  localparam logic [1:0] IF_S_REQ  = 2'd1;
  localparam logic [1:0] IF_S_WAIT = 2'd2;

  // One fetched instruction tagged with the address it came from.
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_skid_buf.sv
// if_skid_buf: one-entry holding buffer for a fetched {pc, inst}.
// Ports: clk, rst (sync, active-high), i_push/i_pop/i_clear controls,
//        i_data entry to store, o_valid/o_data current contents.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  fetch_entry_t i_data,
  output logic         o_valid,
  output fetch_entry_t o_data
);

  logic         r_valid;
  fetch_entry_t r_data;

  // Clear wins over push; push and pop never coincide because a push only
  // happens while decode is stalled and a pop only while it is not.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch. Owns the pc, issues one instruction-memory
// request at a time and presents fetched words to decode.
// Ports: clk, rst (sync, active-high); stall_i/flush_i/new_pc_i from control;
//        rom_req_o/rom_addr_o/rom_gnt_i/rom_rvalid_i/rom_rdata_i to memory;
//        id_pc_o/id_inst_o/id_valid_o registered towards decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_ADDR_W-1:0] PC_STEP  = 32'd4
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] new_pc_i,
  output logic                   rom_req_o,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  input  logic                   rom_gnt_i,
  input  logic                   rom_rvalid_i,
  input  logic [INST_W-1:0]      rom_rdata_i,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o,
  output logic                   id_valid_o
);

  logic [1:0]             r_state,    w_state;
  logic [INST_ADDR_W-1:0] r_pc,       w_pc;
  logic [INST_ADDR_W-1:0] r_fetch_pc, w_fetch_pc;
  logic                   r_drop,     w_drop;
  logic [INST_ADDR_W-1:0] r_id_pc,    w_id_pc;
  logic [INST_W-1:0]      r_id_inst,  w_id_inst;
  logic                   r_id_valid, w_id_valid;

  logic         w_req;
  logic         w_fire;
  logic         w_resp;
  logic         w_deliver;
  logic         w_push;
  logic         w_pop;
  logic         w_clear;
  logic         w_skid_valid;
  fetch_entry_t w_skid_data;
  fetch_entry_t w_rsp_entry;

  // A new request is held off while the skid holds a word, so a response
  // can never arrive with nowhere to go.
  assign w_req       = (r_state == IF_S_REQ) && !w_skid_valid;
  assign w_fire      = w_req && rom_gnt_i;
  assign w_resp      = (r_state == IF_S_WAIT) && rom_rvalid_i;
  assign w_deliver   = w_resp && !r_drop && !flush_i;
  assign w_rsp_entry = '{pc: r_fetch_pc, inst: rom_rdata_i};

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  (w_rsp_entry),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  // Next-state, pc and decode-output selection.
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_fetch_pc = r_fetch_pc;
    w_drop     = r_drop;
    w_id_pc    = r_id_pc;
    w_id_inst  = r_id_inst;
    w_id_valid = r_id_valid;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_clear    = 1'b0;

    case (r_state)
      IF_S_IDLE: w_state = IF_S_REQ;
      IF_S_REQ: begin
        if (w_fire) begin
          w_pc       = r_pc + PC_STEP;
          w_fetch_pc = r_pc;
          // A grant taken in the flush cycle still belongs to the old stream.
          w_drop     = flush_i;
          w_state    = IF_S_WAIT;
        end
      end
      IF_S_WAIT: begin
        if (w_resp) begin
          w_drop  = 1'b0;
          w_state = IF_S_REQ;
        end else if (flush_i) begin
          w_drop  = 1'b1;
        end
      end
      default: w_state = IF_S_IDLE;
    endcase

    if (flush_i) begin
      w_pc       = new_pc_i;
      w_clear    = 1'b1;
      w_id_pc    = '0;
      w_id_inst  = ZERO_WORD;
      w_id_valid = 1'b0;
    end else if (stall_i) begin
      w_push = w_deliver;
    end else if (w_skid_valid) begin
      w_pop      = 1'b1;
      w_id_pc    = w_skid_data.pc;
      w_id_inst  = w_skid_data.inst;
      w_id_valid = 1'b1;
    end else if (w_deliver) begin
      w_id_pc    = r_fetch_pc;
      w_id_inst  = rom_rdata_i;
      w_id_valid = 1'b1;
    end else begin
      w_id_pc    = '0;
      w_id_inst  = ZERO_WORD;
      w_id_valid = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state    <= IF_S_IDLE;
      r_pc       <= RESET_PC;
      r_fetch_pc <= '0;
      r_drop     <= 1'b0;
      r_id_pc    <= '0;
      r_id_inst  <= ZERO_WORD;
      r_id_valid <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_fetch_pc <= w_fetch_pc;
      r_drop     <= w_drop;
      r_id_pc    <= w_id_pc;
      r_id_inst  <= w_id_inst;
      r_id_valid <= w_id_valid;
    end
  end

  assign rom_req_o  = w_req;
  assign rom_addr_o = r_pc;
  assign id_pc_o    = r_id_pc;
  assign id_inst_o  = r_id_inst;
  assign id_valid_o = r_id_valid;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and issues one instruction-memory request at a time over a request/grant plus read-valid handshake.
- Presents each fetched instruction to decode as registered pc/inst/valid outputs.
- Honours the pipeline stall and flush/redirect from control, using a one-entry skid buffer so no returning instruction is lost while stalled.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; first fetch address.
- PC_STEP, 4, PC increment per granted fetch.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high (`RstEnable = 1'b1`).
- stall_i  in  1  decode not accepting: hold id_* outputs.
- flush_i  in  1  discard all in-flight/buffered fetches, restart at new_pc_i.
- new_pc_i  in  32  redirect target, sampled when flush_i=1.
- rom_req_o  out  1  fetch request valid.
- rom_addr_o  out  32  fetch address (= pc).
- rom_gnt_i  in  1  memory accepts the request this cycle.
- rom_rvalid_i  in  1  read data valid for the single outstanding request.
- rom_rdata_i  in  32  instruction word.
- id_pc_o  out  32  pc of instruction presented to decode.
- id_inst_o  out  32  instruction presented to decode.
- id_valid_o  out  1  id_inst_o is a real instruction.

Behaviour:
- Reset (sync, rst=1), all state set regardless of other inputs, mid-transaction included:
  - pc=RESET_PC, state=S_IDLE, drop=0, skid empty.
  - id_pc_o=0, id_inst_o=`ZeroWord`, id_valid_o=0.
  - rom_req_o=0, rom_addr_o=pc.
- FSM S_IDLE: rom_req_o=0 for exactly one cycle after reset is released, then S_REQ.
- FSM S_REQ:
  - rom_req_o = ~skid_valid, rom_addr_o = pc.
  - On req & gnt: pc += PC_STEP, go to S_WAIT.
  - Without a grant the request and address stay stable.
- FSM S_WAIT:
  - rom_req_o=0.
  - On rom_rvalid_i: the word is tagged with the fetched pc (captured at grant); discarded if drop=1, otherwise delivered.
  - drop is cleared and the FSM returns to S_REQ.
- At most one outstanding request.
- Invariant: rom_rvalid_i never coincides with skid_valid=1, because a request is issued only when the skid is empty.
- Delivery, stall_i=0:
  - If skid_valid: outputs are loaded from the skid and the skid empties.
  - Else if a delivered word arrives: outputs are loaded with it.
  - Otherwise a bubble is loaded: id_valid_o=0, id_inst_o=0, id_pc_o=0.
- Delivery, stall_i=1: id_* hold unchanged; a delivered word goes into the skid.
- Latency: grant in cycle N with rvalid in cycle N+k gives id_valid_o=1 in cycle N+k+1 when not stalled.
- Fetch throughput is at most one instruction per 2 cycles (request then response).
- flush_i=1, which has priority over stall_i:
  - pc=new_pc_i, skid cleared, and id_* cleared to a bubble in the next cycle.
  - In S_REQ without a grant: state stays S_REQ and the new pc is requested next cycle.
  - In S_REQ with a grant in the same cycle: the granted access belongs to the old stream, so drop=1 and the FSM goes to S_WAIT.
  - In S_WAIT without rvalid: drop=1 and the FSM stays in S_WAIT.
  - In S_WAIT with rvalid in the same cycle: the word is discarded, drop stays 0, and the FSM goes to S_REQ.
  - In S_IDLE: only pc is updated.
- pc wraps modulo 2^32 (0xFFFFFFFC+4 = 0x00000000); no alignment checking.

Decomposition:
- Shared define file additions:
  - `InstAddrBus`/`InstBus` widths (existing).
  - `RstEnable` (existing).
  - FSM state encodings IF_S_IDLE/IF_S_REQ/IF_S_WAIT (2 bits).
  - `ZeroWord` (existing).
- Sub-module if_skid_buf: one-entry buffer holding {pc, inst} with valid, push, pop and clear.
- FSM, pc and output register remain in if_stage.

Test Plan:
- Reset then free-run, with memory granting immediately and rvalid one cycle after grant -> id_pc_o sequence 0x0,0x4,0x8 with one fetch per 2 cycles; id_inst_o matches ROM words; id_valid_o=0 on the cycles between.
- stall_i held high for 6 cycles while a fetch returns -> id_* frozen and the skid captures the word; rom_req_o stays 0 while the skid is full; on release the skid word appears next cycle with no pc skipped or duplicated.
- flush_i with new_pc_i=0x100 in S_WAIT; stale rvalid arrives 3 cycles later -> stale word never reaches id_*; next request has rom_addr_o=0x100.
- flush_i in the same cycle as rvalid, and separately in the same cycle as gnt -> both stale words dropped; first delivered pc is new_pc_i.
- rst asserted mid-S_WAIT with stall high and skid full -> next cycle all outputs at reset values; one idle cycle; then fetch from RESET_PC.
- RESET_PC=32'hFFFFFFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
